// File: rtl/jt03_pkg.sv
// Shared constants for jt03: register indices, write masks, the SSG volume table and the tick divider.
// Pure definitions; no logic, no latency, no flow control.
package jt03_pkg;

  localparam int TICK_DIV = 8;
  localparam int TICK_W   = $clog2(TICK_DIV);

  localparam logic [3:0] R_TONE_A_FINE   = 4'h0;
  localparam logic [3:0] R_TONE_A_COARSE = 4'h1;
  localparam logic [3:0] R_TONE_B_FINE   = 4'h2;
  localparam logic [3:0] R_TONE_B_COARSE = 4'h3;
  localparam logic [3:0] R_TONE_C_FINE   = 4'h4;
  localparam logic [3:0] R_TONE_C_COARSE = 4'h5;
  localparam logic [3:0] R_NOISE_PER     = 4'h6;
  localparam logic [3:0] R_MIXER         = 4'h7;
  localparam logic [3:0] R_AMP_A         = 4'h8;
  localparam logic [3:0] R_AMP_B         = 4'h9;
  localparam logic [3:0] R_AMP_C         = 4'hA;
  localparam logic [3:0] R_ENV_FINE      = 4'hB;
  localparam logic [3:0] R_ENV_COARSE    = 4'hC;
  localparam logic [3:0] R_ENV_SHAPE     = 4'hD;

  // Registers are stored already masked so readback returns unused bits as 0.
  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    case (idx)
      R_TONE_A_COARSE, R_TONE_B_COARSE, R_TONE_C_COARSE, R_ENV_SHAPE: reg_mask = 8'h0F;
      R_NOISE_PER, R_AMP_A, R_AMP_B, R_AMP_C:                         reg_mask = 8'h1F;
      default:                                                        reg_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] vol_lut(input logic [3:0] lvl);
    case (lvl)
      4'd0:  vol_lut = 8'd0;
      4'd1:  vol_lut = 8'd2;
      4'd2:  vol_lut = 8'd3;
      4'd3:  vol_lut = 8'd4;
      4'd4:  vol_lut = 8'd6;
      4'd5:  vol_lut = 8'd8;
      4'd6:  vol_lut = 8'd11;
      4'd7:  vol_lut = 8'd16;
      4'd8:  vol_lut = 8'd23;
      4'd9:  vol_lut = 8'd32;
      4'd10: vol_lut = 8'd45;
      4'd11: vol_lut = 8'd64;
      4'd12: vol_lut = 8'd90;
      4'd13: vol_lut = 8'd128;
      4'd14: vol_lut = 8'd181;
      default: vol_lut = 8'd255;
    endcase
  endfunction

endpackage

// File: rtl/jt03_psg_tone.sv
// One SSG tone channel: 12-bit up-counter against the period, toggling a square flip-flop on match.
// Advances only on tick; flip-flop changes on the matching tick edge; no flow control.
module jt03_psg_tone (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [11:0] period,
  output logic        tone
);

  logic [11:0] cnt;
  logic [11:0] per_eff;
  logic [11:0] cnt_nx;

  assign per_eff = (period == 12'd0) ? 12'd1 : period;
  assign cnt_nx  = cnt + 12'd1;

  // Equality compare: a period lowered below the count lets the counter wrap through 0xFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (tick) begin
      if (cnt_nx == per_eff) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt_nx;
      end
    end
  end

endmodule

// File: rtl/jt03.sv
// jt03: YM2203-compatible SSG block (bus regfile, 3 tones, noise, envelope, log DAC); FM stays silent.
// Channel levels registered one clk after gate/level change; bus writes never stall. JT03_PWM_EN adds snd_pwm.
module jt03
  import jt03_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [7:0]  din,
  input  logic        addr,
  input  logic        cs_n,
  input  logic        wr_n,
  output logic [7:0]  dout,
  output logic        irq_n,
  output logic        IOA_oe,
  output logic        IOB_oe,
  output logic [7:0]  psg_A,
  output logic [7:0]  psg_B,
  output logic [7:0]  psg_C,
  output logic [15:0] fm_snd,
  output logic [9:0]  psg_snd,
  output logic [15:0] snd,
  output logic [7:0]  debug_view,
  output logic        snd_pwm
);

  logic [7:0] regs [16];
  logic [7:0] reg_sel;
  logic       wr_q;
  logic       wr_pulse, data_wr, env_restart;

  assign wr_pulse    = ~cs_n & ~wr_n & ~wr_q;
  assign data_wr     = wr_pulse & addr & (reg_sel[7:4] == 4'h0);
  assign env_restart = data_wr & (reg_sel[3:0] == R_ENV_SHAPE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      reg_sel <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      wr_q <= ~cs_n & ~wr_n;
      if (wr_pulse && !addr) reg_sel <= din;
      if (data_wr) regs[reg_sel[3:0]] <= din & reg_mask(reg_sel[3:0]);
    end
  end

  always_comb begin
    dout = 8'h00;
    if (!cs_n && addr && reg_sel[7:4] == 4'h0) dout = regs[reg_sel[3:0]];
  end

  // Tick every TICK_DIV cen cycles; noise and envelope use every other tick.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_half;
  logic              tick, slow_tick;

  assign tick      = cen && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign slow_tick = tick & tick_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      tick_half <= 1'b0;
    end else begin
      if (cen) tick_cnt <= tick_cnt + 1'b1;
      if (tick) tick_half <= ~tick_half;
    end
  end

  logic [2:0] tone;
  jt03_psg_tone u_tone_a (.clk(clk), .rst(rst), .tick(tick),
    .period({regs[R_TONE_A_COARSE][3:0], regs[R_TONE_A_FINE]}), .tone(tone[0]));
  jt03_psg_tone u_tone_b (.clk(clk), .rst(rst), .tick(tick),
    .period({regs[R_TONE_B_COARSE][3:0], regs[R_TONE_B_FINE]}), .tone(tone[1]));
  jt03_psg_tone u_tone_c (.clk(clk), .rst(rst), .tick(tick),
    .period({regs[R_TONE_C_COARSE][3:0], regs[R_TONE_C_FINE]}), .tone(tone[2]));

  logic [4:0]  noise_cnt, noise_per, noise_cnt_nx;
  logic [16:0] lfsr;

  assign noise_per    = (regs[R_NOISE_PER][4:0] == 5'd0) ? 5'd1 : regs[R_NOISE_PER][4:0];
  assign noise_cnt_nx = noise_cnt + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_cnt <= '0;
      lfsr      <= 17'd1;
    end else if (slow_tick) begin
      if (noise_cnt_nx == noise_per) begin
        noise_cnt <= '0;
        lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        noise_cnt <= noise_cnt_nx;
      end
    end
  end

  logic [15:0] env_cnt, env_per, env_cnt_nx;
  logic [4:0]  env_step;
  logic        env_held;
  logic        env_cont, env_att, env_alt, env_hold, env_up;
  logic [3:0]  env_lvl;

  assign {env_cont, env_att, env_alt, env_hold} = regs[R_ENV_SHAPE][3:0];
  assign env_per    = ({regs[R_ENV_COARSE], regs[R_ENV_FINE]} == 16'd0) ? 16'd1
                    : {regs[R_ENV_COARSE], regs[R_ENV_FINE]};
  assign env_cnt_nx = env_cnt + 16'd1;
  // step[4] marks odd cycles, which reverse direction when ALT is set.
  assign env_up     = env_att ^ (env_alt & env_step[4]);
  assign env_lvl    = env_held ? ((env_cont & (env_att ^ env_alt)) ? 4'hF : 4'h0)
                    : (env_up ? env_step[3:0] : ~env_step[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_cnt  <= '0;
      env_step <= '0;
      env_held <= 1'b0;
    end else if (env_restart) begin
      env_cnt  <= '0;
      env_step <= '0;
      env_held <= 1'b0;
    end else if (slow_tick) begin
      if (env_cnt_nx == env_per) begin
        env_cnt <= '0;
        if (!env_held) begin
          if (env_step[3:0] == 4'hF && (!env_cont || env_hold)) env_held <= 1'b1;
          else env_step <= env_step + 5'd1;
        end
      end else begin
        env_cnt <= env_cnt_nx;
      end
    end
  end

  logic [4:0] amp [3];
  logic [7:0] chan_nx [3];
  assign amp[0] = regs[R_AMP_A][4:0];
  assign amp[1] = regs[R_AMP_B][4:0];
  assign amp[2] = regs[R_AMP_C][4:0];

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic       gate;
    logic [3:0] lvl;
    assign gate       = (tone[g] | regs[R_MIXER][g]) & (lfsr[0] | regs[R_MIXER][3+g]);
    assign lvl        = amp[g][4] ? env_lvl : amp[g][3:0];
    assign chan_nx[g] = gate ? vol_lut(lvl) : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psg_A <= '0;
      psg_B <= '0;
      psg_C <= '0;
    end else begin
      psg_A <= chan_nx[0];
      psg_B <= chan_nx[1];
      psg_C <= chan_nx[2];
    end
  end

  assign psg_snd    = {2'b00, psg_A} + {2'b00, psg_B} + {2'b00, psg_C};
  assign fm_snd     = 16'd0;
  assign snd        = fm_snd + {1'b0, psg_snd, 5'b0};
  assign irq_n      = 1'b1;
  assign IOA_oe     = regs[R_MIXER][6];
  assign IOB_oe     = regs[R_MIXER][7];
  assign debug_view = reg_sel;

`ifdef JT03_PWM_EN
  logic [16:0] pwm_acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_acc <= '0;
    else     pwm_acc <= {1'b0, pwm_acc[15:0]} + {1'b0, snd ^ 16'h8000};
  end
  assign snd_pwm = pwm_acc[16];
`else
  assign snd_pwm = 1'b0;
`endif

endmodule

// File: tb/tb_jt03.sv
// Directed bench for jt03: register table, bus corner cases, tone period, noise LFSR, envelope and PWM.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_jt03;

  logic        clk = 1'b0;
  logic        rst, cen, addr, cs_n, wr_n;
  logic [7:0]  din, dout, psg_A, psg_B, psg_C, debug_view;
  logic        irq_n, IOA_oe, IOB_oe, snd_pwm;
  logic [15:0] fm_snd, snd;
  logic [9:0]  psg_snd;

  always #5 clk = ~clk;

  jt03 dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
    .dout(dout), .irq_n(irq_n), .IOA_oe(IOA_oe), .IOB_oe(IOB_oe),
    .psg_A(psg_A), .psg_B(psg_B), .psg_C(psg_C), .fm_snd(fm_snd), .psg_snd(psg_snd),
    .snd(snd), .debug_view(debug_view), .snd_pwm(snd_pwm)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] wdat;
    logic [7:0] rexp;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] vol_tab [16] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
                               8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd181, 8'd255};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic reg_wr(input logic [7:0] idx, input logic [7:0] val);
    bus_wr(1'b0, idx);
    bus_wr(1'b1, val);
  endtask

  task automatic reg_rd(input string name, input logic [7:0] exp);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b1; addr = 1'b1;
    #1 chk(name, dout, exp);
    @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; cen = 1'b0; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t, n, ones;
    int edges [3];
    logic [7:0] vals [3];
    logic [7:0] prev;
    logic [7:0] env_seen [16];
    logic [16:0] lfsr_m;

    vecs[0] = '{8'h00, 8'hAB, 8'hAB};
    vecs[1] = '{8'h01, 8'hF1, 8'h01};
    vecs[2] = '{8'h06, 8'hFF, 8'h1F};
    vecs[3] = '{8'h07, 8'h85, 8'h85};
    vecs[4] = '{8'h08, 8'hFF, 8'h1F};
    vecs[5] = '{8'h0D, 8'hFF, 8'h0F};
    vecs[6] = '{8'h0E, 8'h5A, 8'h5A};
    vecs[7] = '{8'h0B, 8'h12, 8'h12};
    vecs[8] = '{8'h0C, 8'h34, 8'h34};

    // Reset state.
    reset_dut();
    chk("rst_psg_A", psg_A, 0);
    chk("rst_psg_B", psg_B, 0);
    chk("rst_psg_C", psg_C, 0);
    chk("rst_psg_snd", psg_snd, 0);
    chk("rst_snd", snd, 0);
    chk("rst_fm", fm_snd, 0);
    chk("rst_dout", dout, 0);
    chk("rst_irq_n", irq_n, 1);
    chk("rst_ioa", IOA_oe, 0);
    chk("rst_iob", IOB_oe, 0);
    chk("rst_debug", debug_view, 0);
    chk("rst_pwm", snd_pwm, 0);

    // Register write / masked readback table.
    for (int i = 0; i < 9; i++) begin
      reg_wr(vecs[i].idx, vecs[i].wdat);
      reg_rd($sformatf("rdback_r%0h", vecs[i].idx), vecs[i].rexp);
    end
    chk("iob_oe_85", IOB_oe, 1);
    chk("ioa_oe_85", IOA_oe, 0);
    reg_wr(8'h07, 8'h45);
    chk("ioa_oe_45", IOA_oe, 1);
    chk("iob_oe_45", IOB_oe, 0);

    // Out-of-range register select.
    reg_wr(8'h20, 8'h77);
    chk("debug_view_20", debug_view, 8'h20);
    reg_rd("rd_r20", 8'h00);
    bus_wr(1'b0, 8'h00);
    reg_rd("r0_untouched", 8'hAB);

    // Read with addr=0 returns 0.
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b1; addr = 1'b0;
    #1 chk("rd_addr0", dout, 8'h00);
    @(negedge clk);
    cs_n = 1'b1;

    // A held strobe writes only once.
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h11;
    @(negedge clk);
    din = 8'h22;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    reg_rd("held_strobe", 8'h11);

    // Tone A, period 0x11B -> half period 2264 clk.
    reset_dut();
    reg_wr(8'h07, 8'h38);
    reg_wr(8'h01, 8'h01);
    reg_wr(8'h00, 8'h1B);
    reg_wr(8'h08, 8'h0F);
    reg_wr(8'h09, 8'h00);
    reg_wr(8'h0A, 8'h00);
    @(negedge clk);
    cen = 1'b1;
    t = 0; n = 0; prev = psg_A;
    while (n < 3 && t < 10000) begin
      @(negedge clk);
      t++;
      if (psg_A !== prev) begin
        edges[n] = t; vals[n] = psg_A; n++; prev = psg_A;
      end
    end
    chk("tone_edge_count", n, 3);
    if (n == 3) begin
      chk("tone_half1", edges[1] - edges[0], 2264);
      chk("tone_half2", edges[2] - edges[1], 2264);
      chk("tone_val0", vals[0], 255);
      chk("tone_val1", vals[1], 0);
      chk("tone_val2", vals[2], 255);
    end
    chk("tone_psg_snd", psg_snd, {2'b00, psg_A});
    chk("tone_snd", snd, {3'b000, psg_A, 5'b0});
    chk("tone_psg_B", psg_B, 0);
    chk("tone_psg_C", psg_C, 0);

    // Asynchronous reset mid-operation clears output before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_psg_A", psg_A, 0);
    chk("async_rst_snd", snd, 0);
    @(negedge clk);
    rst = 1'b0; cen = 1'b0;

    // Envelope attack-hold, period 1.
    reset_dut();
    reg_wr(8'h07, 8'h3F);
    reg_wr(8'h0B, 8'h01);
    reg_wr(8'h0C, 8'h00);
    reg_wr(8'h0D, 8'h0D);
    reg_wr(8'h08, 8'h10);
    @(negedge clk);
    chk("env_start", psg_A, 0);
    cen = 1'b1;
    n = 0; prev = psg_A;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (psg_A !== prev) begin
        if (n < 16) env_seen[n] = psg_A;
        n++; prev = psg_A;
      end
    end
    chk("env_step_count", n, 15);
    for (int i = 0; i < 15 && i < n; i++) chk($sformatf("env_lvl%0d", i + 1), env_seen[i], vol_tab[i + 1]);
    chk("env_hold", psg_A, 255);
    cen = 1'b0;

    // Noise only on A, period 1: one LFSR step per 16 cen pulses.
    reset_dut();
    reg_wr(8'h07, 8'h37);
    reg_wr(8'h08, 8'h0F);
    reg_wr(8'h06, 8'h01);
    @(negedge clk);
    lfsr_m = 17'd1;
    chk("noise_seed", psg_A, 255);
    for (int s = 1; s <= 40; s++) begin
      cen = 1'b1;
      repeat (16) @(negedge clk);
      cen = 1'b0;
      @(negedge clk);
      lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
      chk($sformatf("noise_step%0d", s), psg_A, lfsr_m[0] ? 255 : 0);
    end

    // PWM output with silent mix.
    reset_dut();
    ones = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (snd_pwm) ones++;
    end
`ifdef JT03_PWM_EN
    chk("pwm_duty_half", (ones >= 499 && ones <= 501) ? 1 : 0, 1);
`else
    chk("pwm_tied_low", ones, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
